spi_peripheral: RTL and testbench

SPI Mode-0 target that sits directly upstream of the PWM/output stage inside the onboarding top-level. It synchronises the external SCLK/COPI/nCS pins into the system clock domain and decodes 16-bit write frames into five 8-bit configuration registers. Those registers drive the output-enable, PWM-enable and duty-cycle inputs of the PWM generator.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_peripheral_sync_edge.sv | 33 +++
 rtl/spi_peripheral.sv | 149 ++++++++++++++
 tb/tb_spi_peripheral.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI configuration target.
package spi_pkg;

   localparam int unsigned FRAME_BITS = 16;

   localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
   localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
   localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
   localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
   localparam logic [6:0] ADDR_DUTY      = 7'h04;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMMIT
   } state_t;

endpackage

// File: rtl/spi_peripheral_sync_edge.sv
// Multi-flop synchroniser plus history flop with registered rise/fall pulses.
// The synced level is the history flop, so it lines up with the edge pulses.
module sync_edge #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              hist;

   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= '0;
         hist  <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         chain <= {chain[STAGES-2:0], din};
         hist  <= chain[STAGES-1];
         rise  <= chain[STAGES-1] & ~hist;
         fall  <= ~chain[STAGES-1] & hist;
      end
   end

   assign sync = hist;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write target decoding 16-bit frames into five config registers.
// Optional register readback on cipo is built when SPI_READBACK_EN is defined.
module spi_peripheral
   import spi_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic       cipo,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       frame_err
);

   logic sclk_sync, sclk_rise, sclk_fall;
   logic ncs_sync, ncs_rise, ncs_fall;
   logic copi_sync, copi_rise, copi_fall;
   logic unused_sync;

   state_t      state, state_nxt;
   logic [4:0]  bit_cnt;
   logic        overflow;
   logic [15:0] shreg;
   logic [6:0]  addr;
   logic        frame_ok, wr_en, err_d;

   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .rst(rst), .din(sclk), .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall));
   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ncs (
      .clk(clk), .rst(rst), .din(ncs), .sync(ncs_sync), .rise(ncs_rise), .fall(ncs_fall));
   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_copi (
      .clk(clk), .rst(rst), .din(copi), .sync(copi_sync), .rise(copi_rise), .fall(copi_fall));

   assign addr = shreg[14:8];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Frame is judged on the ncs-rise cycle so the write lands as COMMIT begins.
   always_comb begin
      state_nxt = state;
      frame_ok  = (bit_cnt == 5'(FRAME_BITS)) && !overflow;
      wr_en     = 1'b0;
      err_d     = 1'b0;
      case (state)
         IDLE:    if (ncs_fall) state_nxt = SHIFT;
         SHIFT: begin
            if (ncs_rise) begin
               state_nxt = COMMIT;
               wr_en     = frame_ok && shreg[15] && (addr <= MAX_ADDR);
               err_d     = !frame_ok;
            end
         end
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt         <= '0;
         overflow        <= 1'b0;
         shreg           <= '0;
         frame_err       <= 1'b0;
         en_reg_out_7_0  <= '0;
         en_reg_out_15_8 <= '0;
         en_reg_pwm_7_0  <= '0;
         en_reg_pwm_15_8 <= '0;
         pwm_duty_cycle  <= '0;
      end else begin
         frame_err <= err_d;
         if (state == IDLE && ncs_fall) begin
            bit_cnt  <= '0;
            overflow <= 1'b0;
            shreg    <= '0;
         end else if (state == SHIFT && sclk_rise && !ncs_sync) begin
            if (bit_cnt == 5'(FRAME_BITS)) begin
               overflow <= 1'b1;
            end else begin
               shreg   <= {shreg[14:0], copi_sync};
               bit_cnt <= bit_cnt + 5'd1;
            end
         end
         if (wr_en) begin
            case (addr)
               ADDR_EN_OUT_LO: en_reg_out_7_0  <= shreg[7:0];
               ADDR_EN_OUT_HI: en_reg_out_15_8 <= shreg[7:0];
               ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= shreg[7:0];
               ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= shreg[7:0];
               ADDR_DUTY:      pwm_duty_cycle  <= shreg[7:0];
               default: ;
            endcase
         end
      end
   end

`ifdef SPI_READBACK_EN
   logic [7:0] rd_shreg;
   logic [7:0] rd_data;
   logic       rd_active;
   logic       rd_load;

   // After 8 bits the header sits in shreg[7:0]: R/W in bit 7, address below it.
   always_comb begin
      rd_data = '0;
      rd_load = (state == SHIFT) && (bit_cnt == 5'd8) && !rd_active && !shreg[7];
      if (shreg[6:0] <= MAX_ADDR) begin
         case (shreg[6:0])
            ADDR_EN_OUT_LO: rd_data = en_reg_out_7_0;
            ADDR_EN_OUT_HI: rd_data = en_reg_out_15_8;
            ADDR_EN_PWM_LO: rd_data = en_reg_pwm_7_0;
            ADDR_EN_PWM_HI: rd_data = en_reg_pwm_15_8;
            ADDR_DUTY:      rd_data = pwm_duty_cycle;
            default:        rd_data = '0;
         endcase
      end
   end

   // The fall after bit 8 is skipped so the MSB is still present at the 9th rise.
   always_ff @(posedge clk) begin
      if (rst || state != SHIFT) begin
         rd_shreg  <= '0;
         rd_active <= 1'b0;
      end else if (rd_load) begin
         rd_shreg  <= rd_data;
         rd_active <= 1'b1;
      end else if (rd_active && sclk_fall && bit_cnt >= 5'd9) begin
         rd_shreg <= {rd_shreg[6:0], 1'b0};
      end
   end

   assign cipo        = rd_active && (state == SHIFT) && rd_shreg[7];
   assign unused_sync = &{1'b0, sclk_sync, copi_rise, copi_fall};
`else
   assign cipo        = 1'b0;
   assign unused_sync = &{1'b0, sclk_sync, sclk_fall, copi_rise, copi_fall};
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench for spi_peripheral: directed table, timing/reset sequences,
// and random frames against a frame-level reference model.
module tb_spi_peripheral;

`ifdef SPI_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif
   localparam logic [6:0] MAX_A = 7'h04;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sclk = 1'b0;
   logic       copi = 1'b0;
   logic       ncs = 1'b1;
   logic       cipo;
   logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
   logic       frame_err;

   spi_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(7'h04)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
      .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
      .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
      .pwm_duty_cycle(pwm_duty_cycle), .frame_err(frame_err));

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned err_seen = 0;
   int unsigned cipo_bad = 0;
   bit          rd_window = 1'b0;
   logic [7:0]  mregs [5];

   always @(negedge clk) begin
      if (!rst && frame_err === 1'b1) err_seen++;
      if (!rst && !rd_window && cipo !== 1'b0) cipo_bad++;
   end

   typedef struct {
      logic [31:0] bits;
      int          nbits;
      bit          exp_err;
      logic [39:0] exp_regs;
   } frame_vec_t;

   frame_vec_t vecs [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [39:0] dut_regs();
      return {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};
   endfunction

   function automatic logic [39:0] model_regs();
      return {mregs[0], mregs[1], mregs[2], mregs[3], mregs[4]};
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 5; i++) mregs[i] = 8'h00;
   endfunction

   // Frame-level rules: exactly 16 bits or error; writes land only in range.
   function automatic bit model_apply(input logic [31:0] bits, input int nbits);
      logic [15:0] f;
      if (nbits != 16) return 1'b1;
      f = bits[15:0];
      if (f[15] && f[14:8] <= MAX_A) mregs[int'(f[14:8])] = f[7:0];
      return 1'b0;
   endfunction

   // Bits driven MSB first; cipo sampled just before each sclk rise.
   task automatic spi_frame(input logic [31:0] bits, input int nbits, input bit raise_ncs,
                            output logic [31:0] cap);
      cap = '0;
      ncs = 1'b0;
      tick(6);
      for (int i = 0; i < nbits; i++) begin
         copi = bits[nbits-1-i];
         tick(3);
         cap  = {cap[30:0], cipo};
         sclk = 1'b1;
         tick(6);
         sclk = 1'b0;
         tick(3);
      end
      copi = 1'b0;
      if (raise_ncs) begin
         ncs = 1'b1;
         tick(10);
      end
   endtask

   task automatic run_frame(input logic [31:0] bits, input int nbits, input string tag,
                            output int unsigned obs_err, output logic [31:0] cap);
      int unsigned err_before;
      bit          exp_err;
      bit          is_read16;
      logic [7:0]  exp_rd;
      is_read16 = (nbits == 16) && !bits[15];
      exp_rd    = 8'h00;
      if (is_read16 && RB && bits[14:8] <= MAX_A) exp_rd = mregs[int'(bits[14:8])];
      exp_err    = model_apply(bits, nbits);
      err_before = err_seen;
      rd_window  = (nbits > 0) ? !bits[nbits-1] : 1'b0;
      spi_frame(bits, nbits, 1'b1, cap);
      rd_window  = 1'b0;
      obs_err    = err_seen - err_before;
      check({tag, "_regs"}, 64'(dut_regs()), 64'(model_regs()));
      check({tag, "_err"}, 64'(obs_err), 64'(exp_err));
      if (is_read16) check({tag, "_rd"}, 64'(cap[7:0]), 64'(exp_rd));
   endtask

   initial begin
      int unsigned obs_err;
      int unsigned err_before;
      logic [31:0] cap;
      logic [15:0] f16;
      logic [31:0] bits;
      int          nbits;

      vecs[0] = '{32'h80F0,  16, 1'b0, 40'hF0_00_00_00_00};
      vecs[1] = '{32'h8480,  16, 1'b0, 40'hF0_00_00_00_80};
      vecs[2] = '{32'h422A,  15, 1'b1, 40'hF0_00_00_00_80};
      vecs[3] = '{32'h9011,  16, 1'b0, 40'hF0_00_00_00_80};
      vecs[4] = '{32'h10467, 17, 1'b1, 40'hF0_00_00_00_80};
      vecs[5] = '{32'h8155,  16, 1'b0, 40'hF0_55_00_00_80};
      vecs[6] = '{32'h0155,  16, 1'b0, 40'hF0_55_00_00_80};
      vecs[7] = '{32'h0,      0, 1'b1, 40'hF0_55_00_00_80};

      model_reset();
      rst = 1'b1;
      tick(4);
      rst = 1'b0;
      tick(2);
      check("reset_regs", 64'(dut_regs()), 64'h0);
      check("reset_cipo", 64'(cipo), 64'h0);
      check("reset_err", 64'(frame_err), 64'h0);

      for (int i = 0; i < 8; i++) begin
         run_frame(vecs[i].bits, vecs[i].nbits, $sformatf("vec%0d", i), obs_err, cap);
         check($sformatf("vec%0d_tbl_regs", i), 64'(dut_regs()), 64'(vecs[i].exp_regs));
         check($sformatf("vec%0d_tbl_err", i), 64'(obs_err), 64'(vecs[i].exp_err));
      end

      // Commit latency: visible SYNC_STAGES+2 clocks after the ncs pin rises.
      err_before = err_seen;
      spi_frame(32'h8311, 16, 1'b0, cap);
      void'(model_apply(32'h8311, 16));
      ncs = 1'b1;
      tick(3);
      check("lat_before", 64'(en_reg_pwm_15_8), 64'h00);
      tick(1);
      check("lat_after", 64'(en_reg_pwm_15_8), 64'h11);
      tick(10);
      check("lat_err", 64'(err_seen - err_before), 64'h0);
      check("lat_regs", 64'(dut_regs()), 64'(model_regs()));

      // Reset in the middle of a frame discards it and clears everything.
      err_before = err_seen;
      spi_frame(32'h105, 9, 1'b0, cap);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      model_reset();
      ncs = 1'b1;
      tick(10);
      check("midrst_regs", 64'(dut_regs()), 64'h0);
      check("midrst_err", 64'(err_seen - err_before), 64'h0);
      run_frame(32'h8301, 16, "post_rst", obs_err, cap);
      check("post_rst_pwm_hi", 64'(en_reg_pwm_15_8), 64'h01);

      // Readback of a freshly written register.
      run_frame(32'h82A5, 16, "rb_wr", obs_err, cap);
      run_frame(32'h0200, 16, "rb_rd", obs_err, cap);
      check("rb_value", 64'(cap[7:0]), RB ? 64'hA5 : 64'h00);

      for (int i = 0; i < 40; i++) begin
         f16[15]   = 1'($urandom_range(0, 1));
         f16[14:8] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(5, 127))
                                                 : 7'($urandom_range(0, 4));
         f16[7:0]  = 8'($urandom);
         case ($urandom_range(0, 5))
            0:       begin bits = 32'(f16 >> 1); nbits = 15; end
            1:       begin bits = {15'h0, f16, 1'($urandom)}; nbits = 17; end
            2:       begin bits = 32'h0; nbits = 0; end
            default: begin bits = 32'(f16); nbits = 16; end
         endcase
         run_frame(bits, nbits, $sformatf("rnd%0d", i), obs_err, cap);
      end

      check("cipo_idle", 64'(cipo_bad), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
